// File: rtl/axi_dma_rd_pkg.sv
// Shared AXI encodings and state type for the read/write DMA engines.
package axi_dma_rd_pkg;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [3:0] QOS_VAL     = 4'b1111;
  localparam int         DEFAULT_ID  = 0;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRE,
    RD_START,
    RD_SEQ
  } rd_state_e;

endpackage

// File: rtl/axi_dma_rd_burst_calc.sv
// Burst sizing: next ARLEN from the words still owed, and the address/count
// step taken once the current burst retires. Pure combinational.
module axi_dma_rd_burst_calc #(
  parameter int BITS_TRANS       = 18,
  parameter int AXI_WIDTH_AD     = 32,
  parameter int FIXED_BURST_SIZE = 256
) (
  input  logic [BITS_TRANS-1:0]   i_remain,
  input  logic [AXI_WIDTH_AD-1:0] i_addr,
  input  logic [7:0]              i_len,
  output logic [7:0]              o_len_next,
  output logic [8:0]              o_beats,
  output logic [AXI_WIDTH_AD-1:0] o_addr_next
);

  localparam logic [BITS_TRANS-1:0] MAX_BEATS = BITS_TRANS'(FIXED_BURST_SIZE);

  logic [BITS_TRANS-1:0] w_take;

  // Only evaluated when i_remain != 0, so w_take - 1 never underflows in use.
  assign w_take      = (i_remain > MAX_BEATS) ? MAX_BEATS : i_remain;
  assign o_len_next  = 8'(w_take - BITS_TRANS'(1));
  assign o_beats     = {1'b0, i_len} + 9'd1;
  // Advance by the issued length even if the slave cut the burst short.
  assign o_addr_next = i_addr + (AXI_WIDTH_AD'(o_beats) << 2);

endmodule

// File: rtl/axi_dma_rd.sv
// AXI4 read DMA: splits a job into INCR bursts, one outstanding at a time,
// and forwards each beat straight to the downstream port.
module axi_dma_rd
  import axi_dma_rd_pkg::*;
#(
  parameter int BITS_TRANS       = 18,
  parameter int AXI_WIDTH_ID     = 4,
  parameter int AXI_WIDTH_AD     = 32,
  parameter int AXI_WIDTH_DA     = 32,
  parameter int FIXED_BURST_SIZE = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
  output logic [AXI_WIDTH_ID-1:0] M_ARID,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic [1:0]              M_ARLOCK,
  output logic [3:0]              M_ARCACHE,
  output logic [2:0]              M_ARPROT,
  output logic [3:0]              M_ARQOS,
  output logic [3:0]              M_ARREGION,
  output logic [3:0]              M_ARUSER,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RLAST,
  input  logic [AXI_WIDTH_ID-1:0] M_RID,
  input  logic                    M_RUSER,
  input  logic                    start_dma,
  input  logic [BITS_TRANS-1:0]   num_trans,
  input  logic [AXI_WIDTH_AD-1:0] start_addr,
  output logic [AXI_WIDTH_DA-1:0] outdata,
  output logic                    outdata_vld,
  input  logic                    outdata_rdy,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_check
);

  rd_state_e               r_state;
  logic [BITS_TRANS-1:0]   r_ntrans;
  logic [BITS_TRANS-1:0]   r_burst_cnt;
  logic [AXI_WIDTH_AD-1:0] r_addr;
  logic [7:0]              r_len;
  logic [8:0]              r_beat_cnt;
  logic                    r_err;
  logic                    r_done;

  logic                    w_rhs;
  logic                    w_last_hs;
  logic [7:0]              w_len_next;
  logic [8:0]              w_beats;
  logic [AXI_WIDTH_AD-1:0] w_addr_next;
  logic [BITS_TRANS-1:0]   w_remain;
  logic [BITS_TRANS-1:0]   w_cnt_next;
  logic                    w_unused;

  assign w_unused = ^{M_RID, M_RUSER};

  assign w_remain   = r_ntrans - r_burst_cnt;
  assign w_cnt_next = r_burst_cnt + BITS_TRANS'(w_beats);

  axi_dma_rd_burst_calc #(
    .BITS_TRANS      (BITS_TRANS),
    .AXI_WIDTH_AD    (AXI_WIDTH_AD),
    .FIXED_BURST_SIZE(FIXED_BURST_SIZE)
  ) u_calc (
    .i_remain   (w_remain),
    .i_addr     (r_addr),
    .i_len      (r_len),
    .o_len_next (w_len_next),
    .o_beats    (w_beats),
    .o_addr_next(w_addr_next)
  );

  // AR channel: fields only driven while the request is live.
  assign M_ARVALID  = (r_state == RD_START);
  assign M_ARADDR   = M_ARVALID ? r_addr  : '0;
  assign M_ARLEN    = M_ARVALID ? r_len   : 8'd0;
  assign M_ARSIZE   = M_ARVALID ? SIZE_4B : 3'b000;
  assign M_ARID     = AXI_WIDTH_ID'(DEFAULT_ID);
  assign M_ARBURST  = BURST_INCR;
  assign M_ARLOCK   = 2'b00;
  assign M_ARCACHE  = 4'b0000;
  assign M_ARPROT   = 3'b000;
  assign M_ARQOS    = QOS_VAL;
  assign M_ARREGION = 4'b0000;
  assign M_ARUSER   = 4'b0000;

  // R channel: no buffering, downstream ready is passed straight through.
  assign M_RREADY    = (r_state == RD_SEQ) & outdata_rdy;
  assign w_rhs       = M_RVALID & M_RREADY;
  assign w_last_hs   = w_rhs & M_RLAST;
  assign outdata     = M_RDATA;
  assign outdata_vld = w_rhs;

  assign busy_o = (r_state != RD_IDLE);
  assign done_o = r_done;
  // Flags the retiring burst: an error on any beat (this one included) or a
  // beat count that disagrees with the requested length.
  assign fail_check = w_last_hs &
                      (r_err | (M_RRESP != RESP_OKAY) | (r_beat_cnt != {1'b0, r_len}));

  // Job FSM. done_o rises straight off the last RLAST when data ended the job,
  // and from RD_PRE for an empty job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= RD_IDLE;
      r_ntrans    <= '0;
      r_burst_cnt <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (start_dma) begin
            r_ntrans    <= num_trans;
            r_addr      <= start_addr;
            r_burst_cnt <= '0;
            r_state     <= RD_PRE;
          end
        end
        RD_PRE: begin
          if (r_burst_cnt == r_ntrans) begin
            r_done      <= (r_ntrans == '0);
            r_burst_cnt <= '0;
            r_state     <= RD_IDLE;
          end else begin
            r_len   <= w_len_next;
            r_state <= RD_START;
          end
        end
        RD_START: begin
          if (M_ARREADY) r_state <= RD_SEQ;
        end
        RD_SEQ: begin
          if (w_rhs) begin
            if (M_RRESP != RESP_OKAY) r_err <= 1'b1;
            if (M_RLAST) begin
              r_burst_cnt <= w_cnt_next;
              r_addr      <= w_addr_next;
              r_beat_cnt  <= '0;
              r_err       <= 1'b0;
              r_done      <= (w_cnt_next == r_ntrans);
              r_state     <= RD_PRE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 9'd1;
            end
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

endmodule
